// File: rtl/icache_assoc_pkg.sv
// icache_assoc_pkg: FSM state encoding and address-split helpers shared by the
// set-associative instruction cache files.
package icache_assoc_pkg;

    typedef enum logic [2:0] {
        IC_IDLE,
        IC_LOOKUP,
        IC_REFILL_REQ,
        IC_REFILL_WAIT,
        IC_FLUSH
    } icache_state_e;

    function automatic int offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int line_bytes, input int sets);
        return 32 - offset_bits(line_bytes) - index_bits(sets);
    endfunction

    function automatic int way_bits(input int ways);
        return ways > 1 ? $clog2(ways) : 1;
    endfunction

    function automatic bit ways_legal(input int ways);
        return ways == 1 || ways == 2 || ways == 4;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// harvos_imem_if: single-beat instruction memory bus between the icache (master)
// and the external imem (slave).
interface harvos_imem_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;

    modport master (output req, addr, input rdata, rvalid, fault);
    modport slave  (input req, addr, output rdata, rvalid, fault);
endinterface

// File: rtl/icache_assoc_way.sv
// icache_way: one way of the icache - valid bits, tag array and line data, with a
// shared index for lookup, refill writes and invalidation.
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [index_bits(SETS)-1:0]            i_index,
    input  logic [offset_bits(LINE_BYTES)-3:0]     i_word,
    input  logic [tag_bits(LINE_BYTES, SETS)-1:0]  i_tag,
    input  logic                                   i_wr_en,
    input  logic [31:0]                            i_wr_data,
    input  logic                                   i_set_valid,
    input  logic                                   i_clr_valid,
    output logic                                   o_valid,
    output logic                                   o_hit,
    output logic [31:0]                            o_rdata
);
    localparam int TB    = tag_bits(LINE_BYTES, SETS);
    localparam int WORDS = LINE_BYTES / 4;

    logic [SETS-1:0] r_valid;
    logic [TB-1:0]   r_tag  [SETS];
    logic [31:0]     r_data [SETS*WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= '0;
        else if (i_clr_valid)
            r_valid[i_index] <= 1'b0;
        else if (i_set_valid)
            r_valid[i_index] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_set_valid)
            r_tag[i_index] <= i_tag;
        if (i_wr_en)
            r_data[{i_index, i_word}] <= i_wr_data;
    end

    assign o_valid = r_valid[i_index];
    assign o_hit   = r_valid[i_index] && r_tag[i_index] == i_tag;
    assign o_rdata = r_data[{i_index, i_word}];
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with MPU execute guard,
// round-robin replacement, sequenced flush and fault-aborted refill.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 32,
    parameter int WAYS       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 mpu_exec_allow,
    input  logic [31:0]          cpu_addr,
    input  logic                 cpu_flush,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_rvalid,
    output logic                 cpu_fault,
    output logic                 cpu_busy,
    harvos_imem_if.master        mem
);
    localparam int OB = offset_bits(LINE_BYTES);
    localparam int IB = index_bits(SETS);
    localparam int TB = tag_bits(LINE_BYTES, SETS);
    localparam int WB = OB - 2;
    localparam int VB = way_bits(WAYS);

    localparam logic [2:0] S_IDLE        = IC_IDLE;
    localparam logic [2:0] S_LOOKUP      = IC_LOOKUP;
    localparam logic [2:0] S_REFILL_REQ  = IC_REFILL_REQ;
    localparam logic [2:0] S_REFILL_WAIT = IC_REFILL_WAIT;
    localparam logic [2:0] S_FLUSH       = IC_FLUSH;

    if (!ways_legal(WAYS)) begin : g_bad_ways
        $error("icache_assoc: WAYS must be 1, 2 or 4");
    end

    logic [2:0]    r_state;
    logic [31:2]   r_addr;
    logic [WB-1:0] r_fill;
    logic [VB-1:0] r_victim;
    logic [IB-1:0] r_flush_idx;
    logic          r_flush_pend;
    logic [VB-1:0] r_rr [SETS];

    logic [IB-1:0] w_index;
    logic [WB-1:0] w_word;
    logic [TB-1:0] w_tag;
    logic [WAYS-1:0] w_valid;
    logic [WAYS-1:0] w_way_hit;
    logic [31:0]   w_way_rdata [WAYS];
    logic          w_hit;
    logic [31:0]   w_hit_data;
    logic [VB-1:0] w_victim;
    logic          w_miss;
    logic          w_fill_wr;
    logic          w_fill_done;
    logic          w_nx;
    logic          w_unused_lsbs;

    assign w_unused_lsbs = ^cpu_addr[1:0];

    // The flush sweep borrows the shared index; otherwise everything addresses addr_q's set.
    assign w_index     = (r_state == S_FLUSH) ? r_flush_idx : r_addr[OB +: IB];
    assign w_word      = (r_state == S_REFILL_WAIT) ? r_fill : r_addr[2 +: WB];
    assign w_tag       = r_addr[31 -: TB];
    assign w_miss      = r_state == S_LOOKUP && !w_hit;
    assign w_fill_wr   = r_state == S_REFILL_WAIT && mem.rvalid && !mem.fault;
    assign w_fill_done = w_fill_wr && &r_fill;
    assign w_nx        = r_state == S_IDLE && !cpu_flush && !r_flush_pend && cpu_req && !mpu_exec_allow;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_victim   = r_rr[w_index];
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_valid[i])
                w_victim = VB'(i);
            if (w_way_hit[i]) begin
                w_hit      = 1'b1;
                w_hit_data = w_way_rdata[i];
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(.LINE_BYTES(LINE_BYTES), .SETS(SETS)) u_way (
            .clk,
            .rst_n,
            .i_index     (w_index),
            .i_word      (w_word),
            .i_tag       (w_tag),
            .i_wr_en     (w_fill_wr && r_victim == VB'(w)),
            .i_wr_data   (mem.rdata),
            .i_set_valid (w_fill_done && r_victim == VB'(w)),
            .i_clr_valid (r_state == S_FLUSH || (w_miss && w_victim == VB'(w))),
            .o_valid     (w_valid[w]),
            .o_hit       (w_way_hit[w]),
            .o_rdata     (w_way_rdata[w])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_fill       <= '0;
            r_victim     <= '0;
            r_flush_idx  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_flush || r_flush_pend)
                        r_state <= S_FLUSH;
                    else if (cpu_req && mpu_exec_allow) begin
                        r_state <= S_LOOKUP;
                        r_addr  <= cpu_addr[31:2];
                    end
                end
                S_LOOKUP: begin
                    r_state  <= w_hit ? S_IDLE : S_REFILL_REQ;
                    r_victim <= w_hit ? r_victim : w_victim;
                    r_fill   <= '0;
                end
                S_REFILL_REQ: r_state <= S_REFILL_WAIT;
                S_REFILL_WAIT: begin
                    if (mem.fault)
                        r_state <= S_IDLE;
                    else if (mem.rvalid) begin
                        r_fill  <= r_fill + 1'b1;
                        r_state <= &r_fill ? S_LOOKUP : S_REFILL_REQ;
                    end
                end
                S_FLUSH: begin
                    r_flush_idx <= r_flush_idx + 1'b1;
                    r_state     <= &r_flush_idx ? S_IDLE : S_FLUSH;
                end
                default: r_state <= S_IDLE;
            endcase
            r_flush_pend <= (r_state == S_IDLE) ? 1'b0 : (r_flush_pend || cpu_flush);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                r_rr[s] <= '0;
        end else if (r_state == S_FLUSH)
            r_rr[w_index] <= '0;
        else if (w_fill_done)
            r_rr[w_index] <= (WAYS == 1) ? '0 : r_victim + 1'b1;
    end

    assign cpu_busy   = r_state != S_IDLE;
    assign cpu_rvalid = r_state == S_LOOKUP && w_hit;
    assign cpu_rdata  = cpu_rvalid ? w_hit_data : '0;
    assign cpu_fault  = w_nx || (r_state == S_REFILL_WAIT && mem.fault);
    assign mem.req    = r_state == S_REFILL_REQ;
    assign mem.addr   = mem.req ? {r_addr[31:OB], r_fill, 2'b00} : '0;
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: vector table from the cache test plan, directed flush corners and
// randomized fetches scored against a set/way/round-robin reference model.
module tb_icache_assoc;
    localparam int LB = 16, SETS = 32, WAYS = 2, WORDS = LB / 4;

    logic        clk = 0, rst_n = 0;
    logic        cpu_req = 0, mpu_exec_allow = 1, cpu_flush = 0;
    logic [31:0] cpu_addr = 0, cpu_rdata;
    logic        cpu_rvalid, cpu_fault, cpu_busy;

    harvos_imem_if mem_if ();

    icache_assoc #(.LINE_BYTES(LB), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .mpu_exec_allow(mpu_exec_allow),
        .cpu_addr(cpu_addr), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .cpu_fault(cpu_fault), .cpu_busy(cpu_busy), .mem(mem_if)
    );

    always #5 clk = ~clk;

    // kind: 0 hit, 1 miss+refill, 2 NX fault, 3 refill aborted by mem fault
    typedef struct { logic [31:0] addr; bit allow; int flt; int kind; } vec_t;
    vec_t tbl [13];

    int vectors = 0, miscompares = 0;
    int mem_lat = 0, fault_at = -1, flush_at = -1;
    logic [31:0] req_log [$];
    bit          m_v  [SETS][WAYS];
    int unsigned m_t  [SETS][WAYS];
    int          m_rr [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Imem slave: one word per request after mem_lat extra wait cycles.
    initial begin : responder
        logic [31:0] ra;
        mem_if.rvalid = 0;
        mem_if.fault  = 0;
        mem_if.rdata  = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.rvalid = 0;
            mem_if.fault  = 0;
            if (mem_if.req) begin
                ra = mem_if.addr;
                req_log.push_back(ra);
                repeat (mem_lat + 1) @(posedge clk);
                #1;
                if (req_log.size() - 1 == fault_at) mem_if.fault = 1;
                else begin
                    mem_if.rvalid = 1;
                    mem_if.rdata  = mem_word(ra);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit allow, input int flt, input int kind_in);
        int set = int'((a / LB) % SETS);
        int unsigned tag = a / (LB * SETS);
        int hit_way = -1, victim, kind, cycles = 0, nreq, lat = mem_lat;
        for (int i = WAYS - 1; i >= 0; i--)
            if (m_v[set][i] && m_t[set][i] == tag) hit_way = i;
        kind = kind_in >= 0 ? kind_in : !allow ? 2 : hit_way >= 0 ? 0 : flt >= 0 ? 3 : 1;
        fault_at = (kind == 3) ? flt : -1;
        req_log.delete();
        cpu_req = 1;
        cpu_addr = a;
        mpu_exec_allow = allow;
        if (kind == 2) begin
            @(negedge clk);
            check("nx_fault", cpu_fault, 1);
            check("nx_busy", cpu_busy, 0);
            step();
            cpu_req = 0;
            mpu_exec_allow = 1;
            @(negedge clk);
            check("nx_busy_after", cpu_busy, 0);
            check("nx_mem_reqs", req_log.size(), 0);
            step();
            return;
        end
        step();
        cpu_req = 0;
        do begin
            @(negedge clk);
            cycles++;
            cpu_flush = (cycles == flush_at);
        end while (!cpu_rvalid && !cpu_fault && cycles < 300);
        cpu_flush = 0;
        if (!cpu_rvalid && !cpu_fault) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_timeout: addr %0h got no rvalid/fault within %0d cycles", a, cycles);
        end
        check("rvalid", cpu_rvalid, kind != 3);
        check("refill_fault", cpu_fault, kind == 3);
        check("latency", cycles, kind == 0 ? 1 : kind == 1 ? 2 + WORDS * (2 + lat) : 1 + (flt + 1) * (2 + lat));
        if (kind != 3) check("rdata", cpu_rdata, mem_word(a));
        nreq = kind == 0 ? 0 : kind == 1 ? WORDS : flt + 1;
        check("mem_reqs", req_log.size(), nreq);
        for (int i = 0; i < req_log.size() && i < nreq; i++)
            check("mem_addr", req_log[i], a - a % LB + 4 * i);
        if (kind != 0) begin
            victim = m_rr[set];
            for (int i = WAYS - 1; i >= 0; i--)
                if (!m_v[set][i]) victim = i;
            m_v[set][victim] = (kind == 1);
            m_t[set][victim] = tag;
            if (kind == 1) m_rr[set] = (victim + 1) % WAYS;
        end
        step();
    endtask

    task automatic flush_wait(input string nm);
        int n = 0, w = 0;
        @(negedge clk);
        while (!cpu_busy && w < 4) begin
            @(negedge clk);
            w++;
        end
        while (cpu_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(nm, n, SETS);
        step();
    endtask

    task automatic do_flush();
        cpu_flush = 1;
        step();
        cpu_flush = 0;
        flush_wait("flush_busy_cycles");
        m_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{32'h0000_1004, 1, -1, 1},
            '{32'h0000_1008, 1, -1, 0},
            '{32'h0000_1200, 1, -1, 1},
            '{32'h0000_1400, 1, -1, 1},
            '{32'h0000_1200, 1, -1, 0},
            '{32'h0000_1000, 1, -1, 1},
            '{32'h0000_2000, 0, -1, 2},
            '{32'h0000_3000, 1,  2, 3},
            '{32'h0000_3000, 1, -1, 1},
            '{32'h0000_300C, 1, -1, 0},
            '{32'h0000_1400, 1, -1, 1},
            '{32'h0000_1000, 1, -1, 1},
            '{32'h0000_1400, 1, -1, 0}
        };
        m_clear();
        repeat (2) @(negedge clk);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_fault", cpu_fault, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_mem_req", mem_if.req, 0);
        check("rst_mem_addr", mem_if.addr, 0);
        step();
        rst_n = 1;
        step();

        foreach (tbl[i]) fetch(tbl[i].addr, tbl[i].allow, tbl[i].flt, tbl[i].kind);

        fetch(32'h0000_1000, 1, -1, -1);
        fetch(32'h0000_1200, 1, -1, -1);
        do_flush();
        fetch(32'h0000_1000, 1, -1, 1);
        fetch(32'h0000_1200, 1, -1, 1);

        mem_lat = 0;
        flush_at = 3;
        fetch(32'h0000_5000, 1, -1, 1);
        flush_at = -1;
        flush_wait("pending_flush_busy_cycles");
        m_clear();
        fetch(32'h0000_5000, 1, -1, 1);

        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(0, 2);
            if ($urandom_range(0, 29) == 0) do_flush();
            fetch((32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2),
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 3)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
